// File: rtl/drum_sequencer.sv
// Multi-channel step sequencer: pattern memory, fractional tempo accumulator and an
// IDLE/PLAY/PAUSE transport that emits one-cycle trigger and beat pulses per step.
module drum_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int STEPS       = 8,
    parameter int CLK_HZ      = 50000000,
    parameter int SUBDIV      = 2,
    parameter int DEFAULT_BPM = 120,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SW = $clog2(STEPS),
    localparam int LW = SW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          bpm,
    input  logic                bpm_load,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [STEPS-1:0]    wr_data,
    input  logic [LW-1:0]       length,
    input  logic [CHANNELS-1:0] mute,
    input  logic                start,
    input  logic                pause,
    input  logic                stop,
    output logic [CHANNELS-1:0] trig,
    output logic [SW-1:0]       step_idx,
    output logic                beat_tick,
    output logic                playing
);

    // One step fires each time the accumulated bpm*SUBDIV crosses CLK_HZ*60.
    localparam longint THRESH = longint'(CLK_HZ) * 60;
    localparam int ACC_W = $clog2(THRESH + longint'(255 * SUBDIV) + 1);
    localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t              state;
    logic [7:0]          bpm_reg;
    logic [ACC_W-1:0]    acc;
    logic [LW-1:0]       len_reg;
    logic [STEPS-1:0]    pattern [CHANNELS];

    logic [ACC_W-1:0]    sum;
    logic                fire;
    logic [LW-1:0]       step_inc;
    logic [SW-1:0]       next_step;
    logic [SW-1:0]       rd_step;
    logic [CHANNELS-1:0] column;
    logic                chan_ok;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0 || int'(l) > STEPS) return LW'(STEPS);
        return l;
    endfunction

    function automatic logic is_beat(input logic [SW-1:0] s);
        return (int'(s) % SUBDIV) == 0;
    endfunction

    always_comb begin
        sum       = acc + ACC_W'(bpm_reg) * ACC_W'(SUBDIV);
        fire      = (sum >= THRESH_V);
        step_inc  = LW'(step_idx) + LW'(1);
        next_step = (step_inc == len_reg) ? '0 : step_inc[SW-1:0];
        // Starting from IDLE plays column 0; otherwise the column about to be entered.
        rd_step   = (state == IDLE) ? '0 : next_step;
        for (int c = 0; c < CHANNELS; c++) column[c] = pattern[c][rd_step];
        chan_ok   = (int'(wr_chan) < CHANNELS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bpm_reg   <= 8'(DEFAULT_BPM);
            acc       <= '0;
            len_reg   <= LW'(STEPS);
            step_idx  <= '0;
            trig      <= '0;
            beat_tick <= 1'b0;
            playing   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) pattern[c] <= '0;
        end else begin
            trig      <= '0;
            beat_tick <= 1'b0;
            if (bpm_load) bpm_reg <= bpm;
            // Trigger reads above see the pre-write row; the new row applies from the next read.
            if (wr_en && chan_ok) pattern[wr_chan] <= wr_data;

            if (stop) begin
                state    <= IDLE;
                step_idx <= '0;
                acc      <= '0;
                playing  <= 1'b0;
            end else if (start && state != PLAY) begin
                state   <= PLAY;
                playing <= 1'b1;
                if (state == IDLE) begin
                    len_reg   <= clamp_len(length);
                    step_idx  <= '0;
                    acc       <= '0;
                    trig      <= column & ~mute;
                    beat_tick <= 1'b1;
                end
            end else if (pause && state == PLAY) begin
                state   <= PAUSE;
                playing <= 1'b0;
            end else if (state == PLAY) begin
                if (fire) begin
                    acc       <= sum - THRESH_V;
                    step_idx  <= next_step;
                    trig      <= column & ~mute;
                    beat_tick <= is_beat(next_step);
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_sequencer.sv
// Directed scoreboard bench for drum_sequencer (5 channels, 8 steps, THRESH = 600, SUBDIV = 2).
module tb_drum_sequencer;

    localparam int CH = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    bpm;
    logic          bpm_load;
    logic          wr_en;
    logic [2:0]    wr_chan;
    logic [7:0]    wr_data;
    logic [3:0]    length;
    logic [CH-1:0] mute;
    logic          start;
    logic          pause;
    logic          stop;
    logic [CH-1:0] trig;
    logic [2:0]    step_idx;
    logic          beat_tick;
    logic          playing;

    drum_sequencer #(
        .CHANNELS(CH), .STEPS(8), .CLK_HZ(10), .SUBDIV(2), .DEFAULT_BPM(120)
    ) dut (
        .clk(clk), .reset(reset), .bpm(bpm), .bpm_load(bpm_load),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data), .length(length),
        .mute(mute), .start(start), .pause(pause), .stop(stop),
        .trig(trig), .step_idx(step_idx), .beat_tick(beat_tick), .playing(playing)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            step;
        logic [CH-1:0] trig;
        logic          beat;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any visible step activity must match the next queued expectation.
    int  prev_step = 0;
    ev_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            prev_step = 0;
        end else begin
            if (trig != '0 || beat_tick || int'(step_idx) != prev_step) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got cycle %0d step %0d trig %b beat %b, required no event",
                             cyc, step_idx, trig, beat_tick);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.cyc || int'(step_idx) != mon_e.step ||
                        trig !== mon_e.trig || beat_tick !== mon_e.beat) begin
                        n_bad++;
                        $display("FAIL step_event: got cycle %0d step %0d trig %b beat %b, required cycle %0d step %0d trig %b beat %b",
                                 cyc, step_idx, trig, beat_tick, mon_e.cyc, mon_e.step, mon_e.trig, mon_e.beat);
                    end
                end
            end
            prev_step = int'(step_idx);
        end
    end

    task automatic exp_raw(input int c, input int s, input logic [CH-1:0] t, input logic b);
        ev_t e;
        e.cyc = c; e.step = s; e.trig = t; e.beat = b;
        sb.push_back(e);
    endtask

    // k-th step after a start at edge s0: fires land 3,5,8,10,... edges later at 120 bpm.
    task automatic exp_step(input int s0, input int k, input int s, input logic [CH-1:0] t);
        exp_raw(s0 + (5 * k + 1) / 2, s, t, (s % 2) == 0);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic do_stop(input logic moved);
        if (moved) exp_raw(cyc + 1, 0, '0, 1'b0);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic write_row(input logic [2:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_chan = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, r, l;
        bpm = 8'd0; bpm_load = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_data = '0;
        length = '0; mute = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_trig", 32'(trig), 32'(0));
        check("rst_step", 32'(step_idx), 32'(0));
        check("rst_beat", 32'(beat_tick), 32'(0));
        check("rst_playing", 32'(playing), 32'(0));

        bpm = 8'd120; bpm_load = 1'b1; @(negedge clk); bpm_load = 1'b0;

        // Tempo timing with an empty pattern.
        s = cyc + 1;
        for (int k = 0; k < 4; k++) exp_step(s, k, k, '0);
        pulse_start();
        check("play_on", 32'(playing), 32'(1));
        wait_edge(s + 9);
        do_stop(1'b1);
        check("stop_playing", 32'(playing), 32'(0));
        check("stop_step", 32'(step_idx), 32'(0));

        // Pattern, mute and full-length wrap; the channel-5 write must be dropped.
        write_row(3'd0, 8'b0000_0101);
        write_row(3'd2, 8'b1000_0001);
        write_row(3'd5, 8'hFF);
        mute = 5'b00100;
        s = cyc + 1;
        exp_step(s, 0, 0, 5'b00001);
        exp_step(s, 1, 1, '0);
        exp_step(s, 2, 2, 5'b00001);
        for (int k = 3; k < 8; k++) exp_step(s, k, k, '0);
        exp_step(s, 8, 0, 5'b00101);
        exp_step(s, 9, 1, '0);
        exp_step(s, 10, 2, 5'b00001);
        pulse_start();
        wait_edge(s + 18);
        mute = '0;
        wait_edge(s + 25);
        do_stop(1'b1);

        // Length 3, sampled only at start.
        length = 4'd3;
        s = cyc + 1;
        for (int k = 0; k < 6; k++)
            exp_step(s, k, k % 3, (k % 3 == 0) ? 5'b00101 : (k % 3 == 2) ? 5'b00001 : 5'b00000);
        pulse_start();
        length = 4'd0;
        wait_edge(s + 13);
        do_stop(1'b1);

        // Pause at step 1 with acc = 120, then resume.
        s = cyc + 1;
        exp_step(s, 0, 0, 5'b00101);
        exp_step(s, 1, 1, '0);
        pulse_start();
        wait_edge(s + 3);
        pause = 1'b1; @(negedge clk); pause = 1'b0;
        check("pause_playing", 32'(playing), 32'(0));
        for (int i = 0; i < 20; i++) begin
            pause = (i == 5);
            @(negedge clk);
            check("pause_step", 32'(step_idx), 32'(1));
        end
        pause = 1'b0;
        r = cyc + 1;
        exp_raw(r + 2, 2, 5'b00001, 1'b1);
        exp_raw(r + 5, 3, '0, 1'b0);
        pulse_start();
        check("resume_playing", 32'(playing), 32'(1));
        wait_edge(r + 2);
        pulse_start();
        wait_edge(r + 5);
        do_stop(1'b1);

        // start and stop together stay idle.
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(playing), 32'(0));
        repeat (4) @(negedge clk);
        check("start_stop_still_idle", 32'(playing), 32'(0));

        // Asynchronous reset mid-play clears outputs and pattern.
        s = cyc + 1;
        exp_step(s, 0, 0, 5'b00101);
        exp_step(s, 1, 1, '0);
        exp_step(s, 2, 2, 5'b00001);
        pulse_start();
        wait_edge(s + 5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_trig", 32'(trig), 32'(0));
        check("async_rst_beat", 32'(beat_tick), 32'(0));
        check("async_rst_step", 32'(step_idx), 32'(0));
        check("async_rst_playing", 32'(playing), 32'(0));
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        s = cyc + 1;
        for (int k = 0; k < 3; k++) exp_step(s, k, k, '0);
        pulse_start();
        wait_edge(s + 6);
        do_stop(1'b1);

        // bpm 0 holds position; then write collision and out-of-range channel.
        length = 4'd3;
        s = cyc + 1;
        exp_step(s, 0, 0, '0);
        bpm = 8'd0; bpm_load = 1'b1;
        pulse_start();
        bpm_load = 1'b0;
        wait_edge(s + 1000);
        check("bpm0_playing", 32'(playing), 32'(1));
        check("bpm0_step", 32'(step_idx), 32'(0));
        l = cyc + 1;
        exp_raw(l + 3, 1, '0, 1'b0);
        exp_raw(l + 5, 2, '0, 1'b1);
        exp_raw(l + 8, 0, 5'b00010, 1'b1);
        exp_raw(l + 10, 1, '0, 1'b0);
        exp_raw(l + 13, 2, 5'b00010, 1'b1);
        bpm = 8'd120; bpm_load = 1'b1; @(negedge clk); bpm_load = 1'b0;
        wait_edge(l + 4);
        write_row(3'd1, 8'b0000_0101);
        write_row(3'd5, 8'hFF);
        wait_edge(l + 13);
        do_stop(1'b1);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
